csr_file: RTL and testbench
===========================

# csr_file

Parametrised machine-mode CSR file, successor to the fixed six-register CSR block. It sits between `ex` (CSR instructions) and `clint` (trap entry/return), holding the trap CSRs, `mip`/`mie` interrupt logic and a configurable bank of performance counters. It adds atomic read-modify-write ops, hardware trap-entry and `mret` sequencing, and counter inhibit.

## Interface
Parameters:
- `CNT_WIDTH`, 64: width of every counter (33..64); bits above `CNT_WIDTH` read as 0.
- `NUM_HPM`, 4: number of `mhpmcounter3..` counters (0..8).
- `MTVEC_RESET`, 32'h0: reset value of `mtvec`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `we_i` in 1: `ex` CSR access valid.
- `op_i` in 2: 01 write, 10 set, 11 clear; 00 is read-only (no write).
- `addr_i` in 12: `ex` CSR address (read and write).
- `data_i` in 32: `ex` operand.
- `data_o` out 32: old CSR value (combinational).
- `illegal_o` out 1: `we_i` with an unimplemented address.
- `trap_i` in 1: `clint` trap entry strobe.
- `trap_pc_i` in 32: `mepc` value on trap.
- `trap_cause_i` in 32: `mcause` value on trap.
- `mret_i` in 1: `clint` return strobe.
- `ext_irq_i`, `tmr_irq_i`, `sw_irq_i` in 1 each: async interrupt sources.
- `instret_i` in 1: one instruction retired this cycle.
- `hpm_evt_i` in `NUM_HPM`: event strobes, one per HPM counter.
- `int_req_o` out 1: interrupt pending and enabled.
- `mtvec_o`, `mepc_o`, `mstatus_o` out 32: direct register views for `clint`.

## Operation
- Registers: `mstatus` (MIE bit 3, MPIE bit 7; other bits read 0), `mie`, `mip` (read-only), `mtvec`, `mepc`, `mcause`, `mscratch`, `mcountinhibit` (CY bit 0, IR bit 2, HPMn bit n), `mcycle`, `minstret`, `mhpmcounterN`, plus high halves.
- Write value: op 01 gives `data_i`; op 10 gives old | `data_i`; op 11 gives old & ~`data_i`. Read-only addresses (`mip`, `cycle`/`cycleh`) raise `illegal_o` on op != 00.
- `data_o` always returns the pre-write value. There is no write-forwarding, because RMW semantics require the old value.
- Priority in one cycle: `trap_i` > `mret_i` > `ex` write. A losing `ex` write is dropped; its instruction is flushed.
- Trap: `mepc`←`trap_pc_i`, `mcause`←`trap_cause_i`, MPIE←MIE, MIE←0.
- mret: MIE←MPIE, MPIE←1.
- `mip`: MEIP bit 11, MTIP bit 7, MSIP bit 3. Each is double-flop synchronised from its input.
- `int_req_o` = MIE & |(`mip` & `mie`).
- Counters: `mcycle` increments every cycle unless CY is set. `minstret` increments on `instret_i` unless IR is set. HPMn increments on `hpm_evt_i[n-3]` unless inhibited.
- Counters wrap from all-ones to 0.
- An `ex` write to a counter half wins over that cycle's increment; the other half holds.

## Timing
- Reset: all registers 0 except `mtvec` = `MTVEC_RESET`. `int_req_o` = 0, `illegal_o` = 0. `data_o` = 0 for `addr_i` = 0.
- Reads are combinational, zero latency. Writes are visible on the next cycle.
- Interrupt latency: source edge to `int_req_o` is 2 cycles, given MIE and the `mie` bit are set.
- Writes to MIE or `mie` affect `int_req_o` the cycle after the write edge.
- `trap_i` and `mret_i` asserted together: trap applies, mret is ignored.
- Reset asserted mid-operation clears everything asynchronously. Counters restart from 0 on release.

## Configuration
- `CSR_HPM_EN` defined: `NUM_HPM` HPM counters and their `mcountinhibit` bits exist.
- `CSR_HPM_EN` undefined: no HPM logic. HPM addresses read 0, writes are ignored, and `illegal_o` stays low. `hpm_evt_i` is unused.

## Structure
- Package `csr_pkg`:
  - CSR address constants, including HPM/HPMH base addresses.
  - op encodings.
  - mstatus bit indices (MIE=3, MPIE=7).
  - mip bit indices (MSIP=3, MTIP=7, MEIP=11).
- Sub-module `csr_counter`:
  - `CNT_WIDTH` counter with increment enable and inhibit.
  - Separate low/high 32-bit write ports.
  - Instanced for `mcycle`, `minstret` and each HPM counter.

## Test plan
- Reset release with `MTVEC_RESET`=32'h100: `mtvec_o`=32'h100. After 10 cycles, reading `mcycle` returns 10 (±1 per the read cycle).
- `mscratch`=32'hF0F0 then op 10 with 32'h000F: `data_o`=32'hF0F0, then `mscratch` reads 32'hF0FF. Op 11 with 32'hF000 then leaves 32'h00FF.
- MIE=1, `mie`=32'h80, pulse `tmr_irq_i`: `int_req_o` rises 2 cycles later. Then `trap_i` with pc 32'h40, cause 32'h80000007: `mepc`=32'h40, MIE=0, MPIE=1, `int_req_o`=0. Then `mret_i`: MIE=1.
- Same-cycle `trap_i` and `ex` write of `mepc`=32'h99: `mepc` equals `trap_pc_i`.
- Write `mcycle` low 32'hFFFFFFFF, high 32'hFFFFFFFF (`CNT_WIDTH`=64): next read of both halves is 0 (wrap). Set CY: `mcycle` stays frozen.
- Op 01 to `mip`: `illegal_o`=1 and `mip` is unchanged. Unimplemented address 12'h7C0: `illegal_o`=1 and `data_o`=0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR address map, op encodings and status/interrupt bit indices.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MCNTINH   = 12'h320;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_HPM_BASE  = 12'hB03;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_HPMH_BASE = 12'hB83;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_SET   = 2'b10,
      OP_CLEAR = 2'b11
   } csr_op_e;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   localparam int MIP_MSIP = 3;
   localparam int MIP_MTIP = 7;
   localparam int MIP_MEIP = 11;

   function automatic logic [31:0] csr_wval(
      input csr_op_e     op,
      input logic [31:0] old,
      input logic [31:0] opnd
   );
      logic [31:0] res;
      res = old;
      unique case (op)
         OP_WRITE: res = opnd;
         OP_SET:   res = old | opnd;
         OP_CLEAR: res = old & ~opnd;
         default:  res = old;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/csr_counter.sv
// Wide event counter with split 32-bit write ports and inhibit.
module csr_counter #(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 inhibit,
   input  logic                 wr_lo,
   input  logic                 wr_hi,
   input  logic [31:0]          wdata,
   output logic [CNT_WIDTH-1:0] value
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value <= '0;
      end else if (wr_lo) begin
         value[31:0] <= wdata;
      end else if (wr_hi) begin
         value[CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
      end else if (inc && !inhibit) begin
         value <= value + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap CSRs, interrupt logic, perf counters.
// Optional HPM counter bank is enabled by defining CSR_HPM_EN.
module csr_file
   import csr_pkg::*;
#(
   parameter int          CNT_WIDTH   = 64,
   parameter int          NUM_HPM     = 4,
   parameter logic [31:0] MTVEC_RESET = 32'h0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we_i,
   input  logic [1:0]         op_i,
   input  logic [11:0]        addr_i,
   input  logic [31:0]        data_i,
   output logic [31:0]        data_o,
   output logic               illegal_o,
   input  logic               trap_i,
   input  logic [31:0]        trap_pc_i,
   input  logic [31:0]        trap_cause_i,
   input  logic               mret_i,
   input  logic               ext_irq_i,
   input  logic               tmr_irq_i,
   input  logic               sw_irq_i,
   input  logic               instret_i,
   input  logic [NUM_HPM-1:0] hpm_evt_i,
   output logic               int_req_o,
   output logic [31:0]        mtvec_o,
   output logic [31:0]        mepc_o,
   output logic [31:0]        mstatus_o
);

   localparam logic [31:0] MIE_MASK = 32'h0000_0888;
`ifdef CSR_HPM_EN
   localparam logic [31:0] INH_MASK =
      32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
`else
   localparam logic [31:0] INH_MASK = 32'h5;
`endif

   logic        st_mie;
   logic        st_mpie;
   logic [31:0] mie_reg;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mscratch;
   logic [31:0] cnt_inh;
   logic [2:0]  sync1;
   logic [2:0]  sync2;
   logic [31:0] mip;
   logic [31:0] mstatus;

   logic [CNT_WIDTH-1:0] mcycle;
   logic [CNT_WIDTH-1:0] minstret;
   logic [63:0]          cyc64;
   logic [63:0]          ins64;
   logic [63:0]          hpm_rd;

   logic        hpm_lo;
   logic        hpm_hi;
   logic [31:0] rdata;
   logic        hit;
   logic        ro;
   logic        wen;
   logic [31:0] wval;

   assign mstatus = {24'b0, st_mpie, 3'b0, st_mie, 3'b0};

   always_comb begin
      mip           = '0;
      mip[MIP_MEIP] = sync2[2];
      mip[MIP_MTIP] = sync2[1];
      mip[MIP_MSIP] = sync2[0];
   end

   assign cyc64 = 64'(mcycle);
   assign ins64 = 64'(minstret);

   assign hpm_lo = int'(addr_i) >= int'(CSR_HPM_BASE) &&
                   int'(addr_i) <  int'(CSR_HPM_BASE) + NUM_HPM;
   assign hpm_hi = int'(addr_i) >= int'(CSR_HPMH_BASE) &&
                   int'(addr_i) <  int'(CSR_HPMH_BASE) + NUM_HPM;

   // Read mux: data_o is always the pre-write value, RMW depends on it.
   always_comb begin
      rdata = '0;
      hit   = 1'b1;
      ro    = 1'b0;
      case (addr_i)
         CSR_MSTATUS:   rdata = mstatus;
         CSR_MIE:       rdata = mie_reg;
         CSR_MTVEC:     rdata = mtvec;
         CSR_MCNTINH:   rdata = cnt_inh;
         CSR_MSCRATCH:  rdata = mscratch;
         CSR_MEPC:      rdata = mepc;
         CSR_MCAUSE:    rdata = mcause;
         CSR_MCYCLE:    rdata = cyc64[31:0];
         CSR_MCYCLEH:   rdata = cyc64[63:32];
         CSR_MINSTRET:  rdata = ins64[31:0];
         CSR_MINSTRETH: rdata = ins64[63:32];
         CSR_MIP: begin
            rdata = mip;
            ro    = 1'b1;
         end
         CSR_CYCLE: begin
            rdata = cyc64[31:0];
            ro    = 1'b1;
         end
         CSR_CYCLEH: begin
            rdata = cyc64[63:32];
            ro    = 1'b1;
         end
         default: begin
            hit = hpm_lo | hpm_hi;
            if (hpm_lo) rdata = hpm_rd[31:0];
            if (hpm_hi) rdata = hpm_rd[63:32];
         end
      endcase
   end

   assign data_o    = rdata;
   assign illegal_o = we_i & (~hit | (ro & (op_i != OP_READ)));
   assign wval      = csr_wval(csr_op_e'(op_i), rdata, data_i);

   // Trap and mret pre-empt the ex access, which gets flushed.
   assign wen = we_i & (op_i != OP_READ) & hit & ~ro &
                ~trap_i & ~mret_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_mie   <= 1'b0;
         st_mpie  <= 1'b0;
         mie_reg  <= '0;
         mtvec    <= MTVEC_RESET;
         mepc     <= '0;
         mcause   <= '0;
         mscratch <= '0;
         cnt_inh  <= '0;
      end else if (trap_i) begin
         mepc    <= trap_pc_i;
         mcause  <= trap_cause_i;
         st_mpie <= st_mie;
         st_mie  <= 1'b0;
      end else if (mret_i) begin
         st_mie  <= st_mpie;
         st_mpie <= 1'b1;
      end else if (wen) begin
         case (addr_i)
            CSR_MSTATUS: begin
               st_mie  <= wval[MSTATUS_MIE];
               st_mpie <= wval[MSTATUS_MPIE];
            end
            CSR_MIE:      mie_reg  <= wval & MIE_MASK;
            CSR_MTVEC:    mtvec    <= wval;
            CSR_MCNTINH:  cnt_inh  <= wval & INH_MASK;
            CSR_MSCRATCH: mscratch <= wval;
            CSR_MEPC:     mepc     <= wval;
            CSR_MCAUSE:   mcause   <= wval;
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {ext_irq_i, tmr_irq_i, sw_irq_i};
         sync2 <= sync1;
      end
   end

   assign int_req_o = st_mie & |(mip & mie_reg);
   assign mtvec_o   = mtvec;
   assign mepc_o    = mepc;
   assign mstatus_o = mstatus;

   csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
      .clk     (clk),
      .rst     (rst),
      .inc     (1'b1),
      .inhibit (cnt_inh[0]),
      .wr_lo   (wen && addr_i == CSR_MCYCLE),
      .wr_hi   (wen && addr_i == CSR_MCYCLEH),
      .wdata   (wval),
      .value   (mcycle)
   );

   csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
      .clk     (clk),
      .rst     (rst),
      .inc     (instret_i),
      .inhibit (cnt_inh[2]),
      .wr_lo   (wen && addr_i == CSR_MINSTRET),
      .wr_hi   (wen && addr_i == CSR_MINSTRETH),
      .wdata   (wval),
      .value   (minstret)
   );

`ifdef CSR_HPM_EN
   localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
   logic [3:0]  hpm_idx;
   logic [63:0] hpm64 [HPM_N];

   assign hpm_idx = addr_i[3:0] - 4'd3;

   for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
      logic [CNT_WIDTH-1:0] val;
      csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hpm (
         .clk     (clk),
         .rst     (rst),
         .inc     (hpm_evt_i[i]),
         .inhibit (cnt_inh[3+i]),
         .wr_lo   (wen && hpm_lo && hpm_idx == 4'(i)),
         .wr_hi   (wen && hpm_hi && hpm_idx == 4'(i)),
         .wdata   (wval),
         .value   (val)
      );
      assign hpm64[i] = 64'(val);
   end

   always_comb begin
      hpm_rd = '0;
      for (int i = 0; i < NUM_HPM; i++) begin
         if (hpm_idx == 4'(i)) hpm_rd = hpm64[i];
      end
   end
`else
   logic unused_hpm;
   assign unused_hpm = ^hpm_evt_i;
   assign hpm_rd     = '0;
`endif

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: driver queues expectations per cycle,
// a negedge monitor pops and compares them.
module tb_csr_file;
   import csr_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we_i = 1'b0;
   logic [1:0]  op_i = '0;
   logic [11:0] addr_i = '0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic        illegal_o;
   logic        trap_i = 1'b0;
   logic [31:0] trap_pc_i = '0;
   logic [31:0] trap_cause_i = '0;
   logic        mret_i = 1'b0;
   logic        ext_irq_i = 1'b0;
   logic        tmr_irq_i = 1'b0;
   logic        sw_irq_i = 1'b0;
   logic        instret_i = 1'b0;
   logic [3:0]  hpm_evt_i = '0;
   logic        int_req_o;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;
   logic [31:0] mstatus_o;

   always #5 clk = ~clk;

   csr_file #(
      .CNT_WIDTH   (64),
      .NUM_HPM     (4),
      .MTVEC_RESET (32'h100)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .we_i         (we_i),
      .op_i         (op_i),
      .addr_i       (addr_i),
      .data_i       (data_i),
      .data_o       (data_o),
      .illegal_o    (illegal_o),
      .trap_i       (trap_i),
      .trap_pc_i    (trap_pc_i),
      .trap_cause_i (trap_cause_i),
      .mret_i       (mret_i),
      .ext_irq_i    (ext_irq_i),
      .tmr_irq_i    (tmr_irq_i),
      .sw_irq_i     (sw_irq_i),
      .instret_i    (instret_i),
      .hpm_evt_i    (hpm_evt_i),
      .int_req_o    (int_req_o),
      .mtvec_o      (mtvec_o),
      .mepc_o       (mepc_o),
      .mstatus_o    (mstatus_o)
   );

   typedef enum {S_DATA, S_ILL, S_INT, S_MTVEC, S_MEPC, S_MSTATUS} sel_e;
   typedef struct {
      int          cyc;
      sel_e        sel;
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         case (e.sel)
            S_DATA:    act = data_o;
            S_ILL:     act = {31'b0, illegal_o};
            S_INT:     act = {31'b0, int_req_o};
            S_MTVEC:   act = mtvec_o;
            S_MEPC:    act = mepc_o;
            default:   act = mstatus_o;
         endcase
         checks++;
         if (e.cyc != cyc || act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d/%0d)",
                     e.name, act, e.exp, cyc, e.cyc);
         end
      end
   end

   task automatic cyc_begin();
      @(posedge clk);
      #1;
      we_i   = 1'b0;
      op_i   = OP_READ;
      addr_i = '0;
      data_i = '0;
      trap_i = 1'b0;
      mret_i = 1'b0;
   endtask

   task automatic expect_val(input sel_e s, input string n,
                             input logic [31:0] v);
      exp_t e;
      e.cyc  = cyc;
      e.sel  = s;
      e.name = n;
      e.exp  = v;
      q.push_back(e);
   endtask

   task automatic access(input logic [1:0] op, input logic [11:0] a,
                         input logic [31:0] d, input bit chk,
                         input logic [31:0] exp, input logic ill,
                         input string n);
      cyc_begin();
      we_i   = 1'b1;
      op_i   = op;
      addr_i = a;
      data_i = d;
      if (chk) expect_val(S_DATA, n, exp);
      expect_val(S_ILL, {n, "_ill"}, {31'b0, ill});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // reset state
      repeat (2) cyc_begin();
      expect_val(S_MTVEC,   "rst_mtvec",   32'h100);
      expect_val(S_INT,     "rst_int",     32'h0);
      expect_val(S_ILL,     "rst_ill",     32'h0);
      expect_val(S_DATA,    "rst_data",    32'h0);
      expect_val(S_MEPC,    "rst_mepc",    32'h0);
      expect_val(S_MSTATUS, "rst_mstatus", 32'h0);
      cyc_begin();
      rst = 1'b1;
      repeat (9) cyc_begin();
      access(OP_READ, CSR_MCYCLE,  0, 1, 32'd10, 0, "mcycle10");
      access(OP_READ, CSR_MCYCLEH, 0, 1, 32'd0,  0, "mcycleh0");

      // RMW on mscratch
      access(OP_WRITE, CSR_MSCRATCH, 32'hF0F0, 1, 32'h0,    0, "msc_w");
      access(OP_SET,   CSR_MSCRATCH, 32'h000F, 1, 32'hF0F0, 0, "msc_set");
      access(OP_READ,  CSR_MSCRATCH, 32'h0,    1, 32'hF0FF, 0, "msc_rd1");
      access(OP_CLEAR, CSR_MSCRATCH, 32'hF000, 1, 32'hF0FF, 0, "msc_clr");
      access(OP_READ,  CSR_MSCRATCH, 32'h0,    1, 32'h00FF, 0, "msc_rd2");

      // interrupt path, trap entry and mret
      access(OP_WRITE, CSR_MSTATUS, 32'h8,  1, 32'h0, 0, "mstatus_w");
      access(OP_WRITE, CSR_MIE,     32'h80, 1, 32'h0, 0, "mie_w");
      cyc_begin();
      tmr_irq_i = 1'b1;
      expect_val(S_INT, "irq_t0", 32'h0);
      cyc_begin();
      expect_val(S_INT, "irq_t1", 32'h0);
      cyc_begin();
      expect_val(S_INT, "irq_t2", 32'h1);
      cyc_begin();
      trap_i       = 1'b1;
      trap_pc_i    = 32'h40;
      trap_cause_i = 32'h8000_0007;
      cyc_begin();
      expect_val(S_MEPC,    "trap_mepc",    32'h40);
      expect_val(S_MSTATUS, "trap_mstatus", 32'h80);
      expect_val(S_INT,     "trap_int",     32'h0);
      access(OP_READ, CSR_MCAUSE, 0, 1, 32'h8000_0007, 0, "mcause");
      cyc_begin();
      mret_i = 1'b1;
      cyc_begin();
      tmr_irq_i = 1'b0;
      expect_val(S_MSTATUS, "mret_mstatus", 32'h88);
      expect_val(S_INT,     "mret_int",     32'h1);

      // trap beats a same-cycle ex write
      access(OP_WRITE, CSR_MEPC, 32'h99, 1, 32'h40, 0, "mepc_old");
      trap_i       = 1'b1;
      trap_pc_i    = 32'h1234;
      trap_cause_i = 32'hB;
      access(OP_READ, CSR_MEPC, 0, 1, 32'h1234, 0, "mepc_trapwin");
      expect_val(S_MSTATUS, "trap2_mstatus", 32'h80);

      // trap and mret together: mret ignored
      cyc_begin();
      trap_i    = 1'b1;
      mret_i    = 1'b1;
      trap_pc_i = 32'h2000;
      cyc_begin();
      expect_val(S_MEPC,    "trapmret_mepc",    32'h2000);
      expect_val(S_MSTATUS, "trapmret_mstatus", 32'h0);

      access(OP_WRITE, CSR_MTVEC, 32'h200, 1, 32'h100, 0, "mtvec_w");
      cyc_begin();
      expect_val(S_MTVEC, "mtvec_view", 32'h200);

      // counter wrap and inhibit
      access(OP_WRITE, CSR_MCYCLE,  32'hFFFF_FFFF, 0, 0, 0, "mcyc_lo_w");
      access(OP_WRITE, CSR_MCYCLEH, 32'hFFFF_FFFF, 0, 0, 0, "mcyc_hi_w");
      access(OP_READ, CSR_MCYCLEH, 0, 1, 32'hFFFF_FFFF, 0, "mcyc_ones");
      access(OP_READ, CSR_MCYCLE,  0, 1, 32'h0, 0, "mcyc_wrap_lo");
      access(OP_READ, CSR_MCYCLEH, 0, 1, 32'h0, 0, "mcyc_wrap_hi");
      access(OP_SET,  CSR_MCNTINH, 32'h1, 1, 32'h0, 0, "inh_set");
      access(OP_READ, CSR_MCYCLE,  0, 1, 32'd3, 0, "cy_frozen0");
      access(OP_READ, CSR_MCYCLE,  0, 1, 32'd3, 0, "cy_frozen1");

      // read-only and unimplemented addresses
      cyc_begin();
      sw_irq_i = 1'b1;
      repeat (3) cyc_begin();
      access(OP_WRITE, CSR_MIP, 32'h0, 1, 32'h8, 1, "mip_w");
      access(OP_READ,  CSR_MIP, 32'h0, 1, 32'h8, 0, "mip_rd");
      access(OP_READ,  12'h7C0, 32'h0, 1, 32'h0, 1, "unimpl");
      access(OP_WRITE, CSR_CYCLE, 32'h5, 1, 32'd3, 1, "cycle_ro");
      access(OP_WRITE, CSR_HPM_BASE, 32'h5, 1, 32'h0, 0, "hpm_w");
`ifdef CSR_HPM_EN
      access(OP_READ, CSR_HPM_BASE, 0, 1, 32'h5, 0, "hpm_rd");
`else
      access(OP_READ, CSR_HPM_BASE, 0, 1, 32'h0, 0, "hpm_rd");
`endif

      // asynchronous reset mid-run
      cyc_begin();
      rst = 1'b0;
      expect_val(S_MEPC,    "arst_mepc",    32'h0);
      expect_val(S_MSTATUS, "arst_mstatus", 32'h0);
      expect_val(S_MTVEC,   "arst_mtvec",   32'h100);
      cyc_begin();
      rst = 1'b1;
      sw_irq_i = 1'b0;
      access(OP_READ, CSR_MCYCLE, 0, 1, 32'd1, 0, "mcyc_restart");

      repeat (2) cyc_begin();
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
